sa2_feeder: RTL
===============

# sa2_feeder

Operand feeder and result collector for the 2x2 output-stationary systolic array (4 PEs, 2 activation lanes, 2 weight lanes, 4 x C_WIDTH accumulator outputs). It accepts one K-step operand beat per handshake and drives the array's activation and weight buses with the one-cycle diagonal skew the array needs. It pulses the array's control line to clear the accumulators before each tile. After the pipeline drains it captures the four results and presents them on a valid/ready result port.

## Interface
- WIDTH, 8, operand width per lane
- C_WIDTH, 32, accumulator width per PE
- K_WIDTH, 8, width of tile length k_len
- DRAIN, 4, cycles from the last accepted beat to result capture
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  K_WIDTH  beats in the tile; latched on start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in STREAM
- in_act  in  2*WIDTH  {a0,a1}, row-0 and row-1 activations for this k
- in_weight  in  2*WIDTH  {w0,w1}, col-0 and col-1 weights for this k
- sa_activation  out  2*WIDTH  to array activation bus, {lane0,lane1}
- sa_weight  out  2*WIDTH  to array weight bus, {lane0,lane1}
- sa_control  out  1  to array control; high clears all PE accumulators on that edge
- sa_c_out  in  4*C_WIDTH  array results {C00,C01,C10,C11}
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  4*C_WIDTH  captured {C00,C01,C10,C11}

## Operation
- Reset values: all outputs 0, state IDLE, both skew registers 0.
- IDLE: busy=0. start=1 latches k_len and moves to CLEAR.
- CLEAR: one cycle with sa_control=1. Buses carry zeros. Next state is STREAM, or FLUSH if k_len=0.
- STREAM: in_ready=1. A beat is accepted when in_valid&in_ready. The beat counter increments per accepted beat. Moves to FLUSH on the edge that accepts beat k_len.
- FLUSH: DRAIN cycles, counted by the drain counter. Zeros are injected into both lanes. Moves to RESULT on the last flush cycle. On that edge sa_c_out is registered into res_data.
- RESULT: res_valid=1 and res_data is held stable. res_ready=1 returns to IDLE and clears res_valid on that edge.
- Skew path:
  - lane0 (a0, w0) is registered once;
  - lane1 (a1, w1) is registered twice.
  - Any cycle with no accepted beat (bubble, CLEAR, FLUSH, IDLE) injects 0 on both lanes.
  - Because zero operands add 0, bubbles do not corrupt accumulation.
- Arithmetic is done entirely in the array. This block only moves operands and copies C_WIDTH results unmodified.
- start outside IDLE is ignored. k_len does not change mid-tile.
- If start and res_ready are both high in RESULT, start is ignored and the block returns to IDLE. The earliest new tile is the start seen in IDLE on the following cycle.
- rstn low at any time, including mid-STREAM or mid-RESULT, returns to IDLE with all outputs 0. A partial tile is discarded.

## Timing
- start at edge t: sa_control is high during cycle t+1 (CLEAR), and in_ready rises in cycle t+2.
- Beat accepted at edge e: a0/w0 appear on sa lane0 after edge e, and a1/w1 on lane1 after edge e+1.
- Back-to-back beats are allowed, one per cycle, with no required bubbles.
- Last beat accepted at edge L: res_data is captured at edge L+DRAIN, and res_valid is high from then on.
- DRAIN=4 covers lane-1 skew (1), PE-to-PE hop (1) and PE3 multiply-accumulate register (1), plus one margin cycle.
- Minimum tile period, with res_ready tied high: 1 (start) + 1 (CLEAR) + k_len + DRAIN + 1 (RESULT) cycles.

## Test plan
- A=[[1,2],[3,4]], W=[[5,6],[7,8]], k_len=2, beats {1,3}/{5,6} then {2,4}/{7,8} back-to-back -> res_data {19,22,43,50}; res_valid at edge L+4.
- Same tile with in_valid low for 3 cycles between the beats -> identical res_data; lane outputs are 0 during the bubbles.
- k_len=0 -> CLEAR, then FLUSH, then res_data {0,0,0,0}; in_ready never asserts.
- Second tile with res_ready held low 10 cycles -> res_data stable and res_valid high throughout; start pulses during that time are ignored; the next tile is accepted only after IDLE.
- Two tiles back-to-back with all operands = 0xFF (255) and k_len=3 -> each result is 195075. The second tile is not polluted by the first, which checks the CLEAR pulse.
- rstn pulsed low after 1 of 2 beats -> all outputs 0 and IDLE; a fresh tile then produces the correct {19,22,43,50}.

Source files
------------

// File: rtl/sa2_feeder_if.sv
// rtl/sa2_feeder_if.sv - operand beat stream and result port for sa2_feeder
interface sa2_feeder_if #(
  parameter int WIDTH   = 8,
  parameter int C_WIDTH = 32
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     in_act;
  logic [2*WIDTH-1:0]     in_weight;
  logic                   res_valid;
  logic                   res_ready;
  logic [4*C_WIDTH-1:0]   res_data;

  // master: operand producer / result consumer; slave: the feeder
  modport master (
    output in_valid, in_act, in_weight, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_act, in_weight, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/sa2_feeder.sv
// rtl/sa2_feeder.sv - operand skew feeder and result collector for a 2x2 systolic array
module sa2_feeder #(
  parameter int WIDTH   = 8,
  parameter int C_WIDTH = 32,
  parameter int K_WIDTH = 8,
  parameter int DRAIN   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  output logic                 busy,
  sa2_feeder_if.slave          bus,
  output logic [2*WIDTH-1:0]   sa_activation,
  output logic [2*WIDTH-1:0]   sa_weight,
  output logic                 sa_control,
  input  logic [4*C_WIDTH-1:0] sa_c_out
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_RESULT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [K_WIDTH-1:0]   k_len_q;
  logic [K_WIDTH-1:0]   beat_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [4*C_WIDTH-1:0] res_data_q;

  logic [WIDTH-1:0]     a0_q;
  logic [WIDTH-1:0]     w0_q;
  logic [WIDTH-1:0]     a1_d;
  logic [WIDTH-1:0]     w1_d;
  logic [WIDTH-1:0]     a1_q;
  logic [WIDTH-1:0]     w1_q;

  logic                 in_ready_w;
  logic                 accept;
  logic                 last_beat;
  logic                 last_drain;

  assign in_ready_w = (state == S_STREAM);
  assign accept     = bus.in_valid && in_ready_w;
  assign last_beat  = accept && (beat_cnt == k_len_q - K_WIDTH'(1));
  assign last_drain = (state == S_FLUSH) && (drain_cnt == DW'(DRAIN - 1));

  assign bus.in_ready  = in_ready_w;
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = res_data_q;
  assign busy          = (state != S_IDLE);
  assign sa_control    = (state == S_CLEAR);
  assign sa_activation = {a0_q, a1_q};
  assign sa_weight     = {w0_q, w1_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = (k_len_q == '0) ? S_FLUSH : S_STREAM;
      S_STREAM: if (last_beat) state_nx = S_FLUSH;
      S_FLUSH:  if (last_drain) state_nx = S_RESULT;
      S_RESULT: if (bus.res_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_len_q    <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      res_data_q <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        k_len_q <= k_len;
      end
      if (state == S_CLEAR) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + K_WIDTH'(1);
      end
      if (state == S_FLUSH) begin
        drain_cnt <= drain_cnt + DW'(1);
      end else begin
        drain_cnt <= '0;
      end
      if (last_drain) begin
        res_data_q <= sa_c_out;
      end
    end
  end

  // Lane 1 runs one stage behind lane 0; a zero is shifted in whenever no beat is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a0_q <= '0;
      w0_q <= '0;
      a1_d <= '0;
      w1_d <= '0;
      a1_q <= '0;
      w1_q <= '0;
    end else begin
      a0_q <= accept ? bus.in_act[2*WIDTH-1:WIDTH]    : '0;
      w0_q <= accept ? bus.in_weight[2*WIDTH-1:WIDTH] : '0;
      a1_d <= accept ? bus.in_act[WIDTH-1:0]          : '0;
      w1_d <= accept ? bus.in_weight[WIDTH-1:0]       : '0;
      a1_q <= a1_d;
      w1_q <= w1_d;
    end
  end

endmodule
